// File: rtl/dff_arb_pkg.sv
// Shared definitions for the dff_reg_arbiter block: FSM state encoding,
// burst counter width and a constant-evaluable clog2 helper.
package dff_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    LOCKED = 2'd2
  } arb_state_t;

  localparam int BURST_W = 4;

  // Bits needed to index v items; usable in port and parameter declarations.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/dff_reg_arbiter_rr_pick.sv
// Combinational rotate-priority selector: first set request at or above ptr,
// wrapping around, returned one-hot with a valid flag.
module rr_pick
  import dff_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]        req,
  input  logic [clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]        sel,
  output logic                   valid
);

  always_comb begin
    sel   = '0;
    valid = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!valid && req[(int'(ptr) + k) % NREQ]) begin
        sel[(int'(ptr) + k) % NREQ] = 1'b1;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dff_reg_arbiter.sv
// Round-robin write arbiter for a shared WIDTH-bit register.
// Define RR_LOCK_EN to enable the LOCKED burst state and the lock input.
module dff_reg_arbiter
  import dff_arb_pkg::*;
#(
  parameter int               NREQ      = 4,
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   CLR,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        lock,
  input  logic [NREQ*WIDTH-1:0]  wdata,
  output logic [NREQ-1:0]        gnt,
  output logic [WIDTH-1:0]       Q,
  output logic [clog2(NREQ)-1:0] owner,
  output logic                   busy
);

  localparam int PW = clog2(NREQ);

  arb_state_t      state, state_n;
  logic [NREQ-1:0] gnt_n;
  logic [PW-1:0]   gidx, gidx_n;
  logic [PW-1:0]   ptr, ptr_n;
  logic [WIDTH-1:0] q_n;
  logic [PW-1:0]   owner_n;
  logic [NREQ-1:0] pick_sel;
  logic            pick_valid;
  logic [PW-1:0]   pick_idx;
  logic [PW-1:0]   ptr_after;

`ifdef RR_LOCK_EN
  logic [BURST_W-1:0] cnt, cnt_n;
`else
  logic unused_cfg;
  assign unused_cfg = (^lock) ^ (MAX_BURST > 0);
`endif

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .sel   (pick_sel),
    .valid (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_sel[i]) pick_idx = PW'(i);
    end
  end

  assign ptr_after = (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      state <= IDLE;
      gnt   <= '0;
      gidx  <= '0;
      ptr   <= '0;
      Q     <= RESET_VAL;
      owner <= '0;
`ifdef RR_LOCK_EN
      cnt   <= '0;
`endif
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      gidx  <= gidx_n;
      ptr   <= ptr_n;
      Q     <= q_n;
      owner <= owner_n;
`ifdef RR_LOCK_EN
      cnt   <= cnt_n;
`endif
    end
  end

  // A write only ever happens from the granted slice while req of that slice is high.
  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    gidx_n  = gidx;
    ptr_n   = ptr;
    q_n     = Q;
    owner_n = owner;
`ifdef RR_LOCK_EN
    cnt_n   = cnt;
`endif
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_n = GRANT;
          gnt_n   = pick_sel;
          gidx_n  = pick_idx;
        end
      end
      GRANT: begin
        state_n = IDLE;
        gnt_n   = '0;
        if (req[gidx]) begin
          q_n     = wdata[gidx*WIDTH +: WIDTH];
          owner_n = gidx;
          ptr_n   = ptr_after;
`ifdef RR_LOCK_EN
          if (lock[gidx] && (MAX_BURST > 1)) begin
            state_n = LOCKED;
            gnt_n   = gnt;
            cnt_n   = BURST_W'(1);
          end
`endif
        end
      end
`ifdef RR_LOCK_EN
      LOCKED: begin
        if (req[gidx] && lock[gidx]) begin
          q_n     = wdata[gidx*WIDTH +: WIDTH];
          owner_n = gidx;
          cnt_n   = cnt + 1'b1;
          if (cnt + 1'b1 == BURST_W'(MAX_BURST)) begin
            state_n = IDLE;
            gnt_n   = '0;
          end
        end else begin
          state_n = IDLE;
          gnt_n   = '0;
        end
      end
`endif
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase
  end

endmodule
